down_timer: RTL and testbench

- Programmable down-counting timer: the countdown counterpart to the catalog up counter.
- A start value is loaded through a valid/ready handshake and counted down to zero while enabled.
- A one-cycle terminal-count pulse fires at zero; optional auto-reload gives a periodic tick.
- Used as a catalog element for delays, timeouts and periodic event generation.

---
 rtl/down_timer.sv | 133 +++++++++++++
 tb/tb_down_timer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// ---------------------------------------------------------------------------
// down_timer
//
// Programmable down-counting timer. A start value is loaded through a
// valid/ready handshake while idle and is counted down to zero on enabled
// cycles. Reaching zero produces a registered one-cycle terminal-count pulse.
// With auto_reload set at that moment the timer restarts from the loaded
// value with no dead cycle, which gives a periodic tick.
//
// Parameters
//   n   width of the count value, reload register and load_value
//   cw  width of the saturating terminal-count event counter
//
// Ports
//   clk          clock, all state updates on the rising edge
//   clr_n        synchronous active-low reset, overrides every other input
//   en           count enable, low freezes the count while running
//   load_valid   load request, load_value is valid
//   load_value   start / reload value
//   load_ready   high while idle, a load is accepted this cycle
//   auto_reload  sampled at terminal count: 1 reloads, 0 stops
//   abort        cancels a running count without a terminal pulse
//   r            current count value
//   busy         high while counting
//   tc           one-cycle terminal-count pulse
//   tc_cnt       number of tc pulses since reset, saturating
// ---------------------------------------------------------------------------
module down_timer #(
    parameter int n  = 32,
    parameter int cw = 8
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          en,
    input  logic          load_valid,
    input  logic [n-1:0]  load_value,
    output logic          load_ready,
    input  logic          auto_reload,
    input  logic          abort,
    output logic [n-1:0]  r,
    output logic          busy,
    output logic          tc,
    output logic [cw-1:0] tc_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [n-1:0]  ONE     = n'(1);
    localparam logic [cw-1:0] CNT_MAX = '1;

    state_t        state;
    state_t        state_nx;
    logic [n-1:0]  reload_reg;
    logic [n-1:0]  r_nx;
    logic [n-1:0]  reload_nx;
    logic          tc_nx;

    // The handshake and the busy flag are pure decodes of the state, so a
    // load is never accepted while a count is in progress.
    assign load_ready = (state == IDLE);
    assign busy       = (state == RUN);

    // Next-state and next-value logic. In RUN the priority is abort, then
    // terminal count, then plain decrement. A zero-length load never enters
    // RUN; it only raises tc for one cycle. The terminal check is on r==1 so
    // tc rises on the same edge that r reaches zero (or reloads), which makes
    // a load of N take exactly N enabled cycles.
    always_comb begin
        state_nx  = state;
        r_nx      = r;
        reload_nx = reload_reg;
        tc_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    if (load_value != '0) begin
                        r_nx      = load_value;
                        reload_nx = load_value;
                        state_nx  = RUN;
                    end else begin
                        tc_nx = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    r_nx     = '0;
                    state_nx = IDLE;
                end else if (en) begin
                    if (r == ONE) begin
                        tc_nx = 1'b1;
                        if (auto_reload) begin
                            r_nx = reload_reg;
                        end else begin
                            r_nx     = '0;
                            state_nx = IDLE;
                        end
                    end else if (r > ONE) begin
                        r_nx = r - ONE;
                    end
                end
            end
            default: begin
                r_nx     = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // State and datapath registers. The event counter sticks at its maximum
    // instead of wrapping, while tc itself still pulses after saturation.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state      <= IDLE;
            r          <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
            tc_cnt     <= '0;
        end else begin
            state      <= state_nx;
            r          <= r_nx;
            reload_reg <= reload_nx;
            tc         <= tc_nx;
            if (tc_nx && (tc_cnt != CNT_MAX)) begin
                tc_cnt <= tc_cnt + cw'(1);
            end
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// ---------------------------------------------------------------------------
// tb_down_timer
//
// Bench for down_timer. Directed scenarios followed by random traffic, all
// checked against a reference model that tracks the timer as "enabled cycles
// elapsed since the load" modulo the loaded period, plus an unbounded pulse
// count that is clamped when compared.
// ---------------------------------------------------------------------------
module tb_down_timer;

    localparam int N  = 32;
    localparam int CW = 8;
    localparam longint unsigned CNT_SAT = (64'd1 << CW) - 1;

    logic          clk;
    logic          clr_n;
    logic          en;
    logic          load_valid;
    logic [N-1:0]  load_value;
    logic          load_ready;
    logic          auto_reload;
    logic          abort;
    logic [N-1:0]  r;
    logic          busy;
    logic          tc;
    logic [CW-1:0] tc_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit              m_busy    = 1'b0;
    longint unsigned m_period  = 0;
    longint unsigned m_elapsed = 0;
    bit              m_tc      = 1'b0;
    longint unsigned m_count   = 0;

    down_timer #(.n(N), .cw(CW)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .en          (en),
        .load_valid  (load_valid),
        .load_value  (load_value),
        .load_ready  (load_ready),
        .auto_reload (auto_reload),
        .abort       (abort),
        .r           (r),
        .busy        (busy),
        .tc          (tc),
        .tc_cnt      (tc_cnt)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remaining count is the period minus the progress into the current period
    function automatic logic [N-1:0] exp_r();
        if (!m_busy) return '0;
        return N'(m_period - (m_elapsed % m_period));
    endfunction

    function automatic logic [CW-1:0] exp_cnt();
        if (m_count > CNT_SAT) return CW'(CNT_SAT);
        return CW'(m_count);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        if (!clr_n) begin
            m_busy    = 1'b0;
            m_period  = 0;
            m_elapsed = 0;
            m_tc      = 1'b0;
            m_count   = 0;
        end else begin
            m_tc = 1'b0;
            if (!m_busy) begin
                if (load_valid) begin
                    if (load_value != '0) begin
                        m_busy    = 1'b1;
                        m_period  = longint'(load_value);
                        m_elapsed = 0;
                    end else begin
                        m_tc    = 1'b1;
                        m_count = m_count + 1;
                    end
                end
            end else if (abort) begin
                m_busy = 1'b0;
            end else if (en) begin
                m_elapsed = m_elapsed + 1;
                if ((m_elapsed % m_period) == 0) begin
                    m_tc    = 1'b1;
                    m_count = m_count + 1;
                    if (!auto_reload) m_busy = 1'b0;
                end
            end
        end
    endtask

    // Compare every output against the model
    task automatic checkOutput(input string tag);
        checks++;
        assert (r === exp_r()) else begin
            errors++;
            $error("[TB] FAIL %s r: observed=%0h expected=%0h", tag, r, exp_r());
        end
        checks++;
        assert (busy === m_busy) else begin
            errors++;
            $error("[TB] FAIL %s busy: observed=%0b expected=%0b", tag, busy, m_busy);
        end
        checks++;
        assert (load_ready === !m_busy) else begin
            errors++;
            $error("[TB] FAIL %s load_ready: observed=%0b expected=%0b", tag, load_ready, !m_busy);
        end
        checks++;
        assert (tc === m_tc) else begin
            errors++;
            $error("[TB] FAIL %s tc: observed=%0b expected=%0b", tag, tc, m_tc);
        end
        checks++;
        assert (tc_cnt === exp_cnt()) else begin
            errors++;
            $error("[TB] FAIL %s tc_cnt: observed=%0d expected=%0d", tag, tc_cnt, exp_cnt());
        end
    endtask

    // Spot check of a hand-derived value from the scenario descriptions
    task automatic checkConst(input string tag, input longint unsigned observed,
                              input longint unsigned expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock edge: update model, then sample #1 after the edge
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Hold a set of inputs for a number of cycles, checking each cycle
    task automatic applyStimulus(input string tag, input logic c, input logic e,
                                 input logic lv, input logic [N-1:0] val,
                                 input logic ar, input logic ab, input int cycles);
        clr_n       = c;
        en          = e;
        load_valid  = lv;
        load_value  = val;
        auto_reload = ar;
        abort       = ab;
        for (int i = 0; i < cycles; i++) step(tag);
    endtask

    initial begin
        clr_n = 1'b0; en = 1'b0; load_valid = 1'b0; load_value = '0;
        auto_reload = 1'b0; abort = 1'b0;

        // Reset state
        applyStimulus("reset", 0, 0, 0, 0, 0, 0, 2);

        // Load 5, single shot
        applyStimulus("load5", 1, 1, 1, 5, 0, 0, 1);
        checkConst("load5_r", r, 5);
        applyStimulus("run5", 1, 1, 0, 0, 0, 0, 5);
        checkConst("run5_end_r", r, 0);
        checkConst("run5_end_tc", tc, 1);
        checkConst("run5_end_cnt", tc_cnt, 1);
        applyStimulus("after5", 1, 1, 0, 0, 0, 0, 1);

        // Load 3 with auto-reload, 9 enabled cycles
        applyStimulus("reset2", 0, 0, 0, 0, 0, 0, 1);
        applyStimulus("load3", 1, 1, 1, 3, 1, 0, 1);
        applyStimulus("auto3", 1, 1, 0, 0, 1, 0, 9);
        checkConst("auto3_cnt", tc_cnt, 3);
        checkConst("auto3_busy", busy, 1);
        applyStimulus("auto3b", 1, 1, 0, 0, 1, 0, 1);
        applyStimulus("auto3_stop", 1, 1, 0, 0, 0, 0, 3);

        // Load 4 with gated enable
        applyStimulus("load4", 1, 1, 1, 4, 0, 0, 1);
        applyStimulus("gate1", 1, 1, 0, 0, 0, 0, 1);
        applyStimulus("gate0", 1, 0, 0, 0, 0, 0, 1);
        checkConst("gate_frozen", r, 3);
        applyStimulus("gate1", 1, 1, 0, 0, 0, 0, 1);
        applyStimulus("gate0", 1, 0, 0, 0, 0, 0, 1);
        applyStimulus("gate1", 1, 1, 0, 0, 0, 0, 2);
        checkConst("gate_tc", tc, 1);

        // Load 10, abort at 7, then load 2
        applyStimulus("load10", 1, 1, 1, 10, 0, 0, 1);
        applyStimulus("run10", 1, 1, 0, 0, 0, 0, 3);
        checkConst("run10_r", r, 7);
        applyStimulus("abort", 1, 1, 0, 0, 0, 1, 1);
        applyStimulus("idle_abort", 1, 1, 0, 0, 0, 1, 1);
        applyStimulus("load2", 1, 1, 1, 2, 0, 0, 1);
        applyStimulus("run2", 1, 1, 0, 0, 0, 0, 3);

        // Zero-length load, then load ignored while running
        applyStimulus("load0", 1, 1, 1, 0, 0, 0, 1);
        checkConst("load0_tc", tc, 1);
        checkConst("load0_busy", busy, 0);
        applyStimulus("after0", 1, 1, 0, 0, 0, 0, 1);
        applyStimulus("load5b", 1, 0, 1, 5, 0, 0, 1);
        applyStimulus("ignored", 1, 0, 1, 9, 0, 0, 3);
        checkConst("ignored_r", r, 5);
        applyStimulus("finish5", 1, 1, 1, 9, 0, 0, 5);
        applyStimulus("accept9", 1, 1, 1, 9, 0, 0, 1);
        checkConst("accept9_r", r, 9);
        applyStimulus("abort9", 1, 1, 0, 0, 0, 1, 1);

        // Reset mid-count
        applyStimulus("load8", 1, 1, 1, 8, 1, 0, 1);
        applyStimulus("run8", 1, 1, 0, 0, 1, 0, 2);
        checkConst("run8_r", r, 6);
        applyStimulus("midreset", 0, 1, 1, 4, 1, 1, 1);
        checkConst("midreset_cnt", tc_cnt, 0);

        // Saturation: period 1 with reload ticks every cycle
        applyStimulus("load1", 1, 1, 1, 1, 1, 0, 1);
        applyStimulus("sat", 1, 1, 0, 0, 1, 0, 262);
        checkConst("sat_cnt", tc_cnt, CNT_SAT);
        checkConst("sat_tc", tc, 1);
        applyStimulus("sat_abort", 1, 1, 0, 0, 1, 1, 1);

        // Largest count value
        applyStimulus("loadmax", 1, 1, 1, '1, 0, 0, 1);
        applyStimulus("runmax", 1, 1, 0, 0, 0, 0, 3);
        checkConst("runmax_r", r, 64'hFFFF_FFFC);
        applyStimulus("abortmax", 1, 1, 0, 0, 0, 1, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            clr_n       = ($urandom_range(0, 63) != 0);
            en          = ($urandom_range(0, 3) != 0);
            load_valid  = ($urandom_range(0, 2) == 0);
            load_value  = N'($urandom_range(0, 6));
            auto_reload = $urandom_range(0, 1) == 1;
            abort       = ($urandom_range(0, 15) == 0);
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
